// File: rtl/dma_inter_sched.sv
// dma_inter_sched
//   Block-granular round-robin scheduler that shares the single DW-bit write
//   port of the dma_inter ping-pong FIFO among NUM_CH source channels. A
//   channel is granted only when it has a whole block ready. It then streams
//   exactly BLK_LEN words, so every FIFO half holds one channel's data.
//
// Ports
//   clk        single clock
//   rst        synchronous, active-high reset
//   en         scheduler enable (gates new grants only)
//   blk_req    per-channel "full block available" level
//   req_valid  per-channel word valid
//   req_data   per-channel word, channel i at [i*DW +: DW]
//   req_ready  per-channel word accept
//   out_valid  word valid to FIFO valid_in
//   out_data   word to FIFO data_in
//   out_ch     channel tag of out_data
//   blk_start  pulse with the first word of a block
//   blk_done   pulse with the last word of a block
//   busy       scheduler not idle
//   blk_cnt    completed block counter, wraps at 2^16
module dma_inter_sched #(
  parameter int NUM_CH  = 4,
  parameter int BLK_LEN = 512,
  parameter int GAP     = 2,
  parameter int DW      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_CH-1:0]    blk_req,
  input  logic [NUM_CH-1:0]    req_valid,
  input  logic [NUM_CH*DW-1:0] req_data,
  output logic [NUM_CH-1:0]    req_ready,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic [2:0]           out_ch,
  output logic                 blk_start,
  output logic                 blk_done,
  output logic                 busy,
  output logic [15:0]          blk_cnt
);

  localparam int CW = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLK_LEN - 1);
  localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [2:0]    rr_ptr_q, rr_ptr_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    gap_cnt_q, gap_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [2:0]    out_ch_q, out_ch_d;
  logic          blk_start_q, blk_start_d;
  logic          blk_done_q, blk_done_d;
  logic [15:0]   blk_cnt_q, blk_cnt_d;

  logic          pick_found;
  logic [2:0]    pick;
  logic [DW-1:0] sel_data;
  logic          sel_valid;
  logic          xfer;

  // Round-robin search: first look at channels at or above rr_ptr, then
  // wrap around to the low channels. This avoids a modulo for any NUM_CH.
  always_comb begin
    pick_found = 1'b0;
    pick       = 3'd0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (!pick_found && blk_req[j] && (3'(j) >= rr_ptr_q)) begin
        pick_found = 1'b1;
        pick       = 3'(j);
      end
    end
    for (int j = 0; j < NUM_CH; j++) begin
      if (!pick_found && blk_req[j]) begin
        pick_found = 1'b1;
        pick       = 3'(j);
      end
    end
  end

  // Granted-channel mux; ready is decoded from registered state only.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    req_ready = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (gnt_q == 3'(j)) begin
        sel_data     = req_data[j*DW +: DW];
        sel_valid    = req_valid[j];
        req_ready[j] = (state_q == S_BURST);
      end
    end
  end

  assign xfer = (state_q == S_BURST) && sel_valid;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    gap_cnt_d   = gap_cnt_q;
    out_valid_d = xfer;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    blk_start_d = xfer && (cnt_q == '0);
    blk_done_d  = xfer && (cnt_q == CNT_LAST);
    blk_cnt_d   = blk_cnt_q;

    if (xfer) begin
      out_data_d = sel_data;
      out_ch_d   = gnt_q;
    end
    if (blk_done_d) begin
      blk_cnt_d = blk_cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (en && pick_found) begin
          gnt_d   = pick;
          cnt_d   = '0;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        // The burst is held open until BLK_LEN words are accepted; en and
        // blk_req are deliberately not looked at here.
        if (xfer) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            rr_ptr_d  = (gnt_q == 3'(NUM_CH - 1)) ? 3'd0 : gnt_q + 3'd1;
            gap_cnt_d = 4'd0;
            state_d   = (GAP == 0) ? S_IDLE : S_GAP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = 4'd0;
          state_d   = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= 3'd0;
      gnt_q       <= 3'd0;
      cnt_q       <= '0;
      gap_cnt_q   <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= 3'd0;
      blk_start_q <= 1'b0;
      blk_done_q  <= 1'b0;
      blk_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      blk_start_q <= blk_start_d;
      blk_done_q  <= blk_done_d;
      blk_cnt_q   <= blk_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign blk_start = blk_start_q;
  assign blk_done  = blk_done_q;
  assign busy      = (state_q != S_IDLE);
  assign blk_cnt   = blk_cnt_q;

endmodule
